// File: rtl/xeng_pkg.sv
// Shared definitions for the X-engine output post-processor.
// Holds the geometry helpers, the lane-slice index and the offset-binary flip mask.
package xeng_pkg;

  typedef enum logic {
    FRAME_IDLE   = 1'b0,
    FRAME_ACTIVE = 1'b1
  } frame_state_e;

  function automatic int unsigned p_lanes(input int unsigned p_factor_bits);
    return 32'd1 << p_factor_bits;
  endfunction

  function automatic int unsigned bus_width(input int unsigned n_pols,
                                            input int unsigned p_factor_bits,
                                            input int unsigned bitwidth);
    return n_pols * p_lanes(p_factor_bits) * 2 * bitwidth;
  endfunction

  function automatic int unsigned stagger_step(input int unsigned first_dsp_registers,
                                               input int unsigned dsp_registers);
    return 1 + dsp_registers - first_dsp_registers;
  endfunction

  function automatic int unsigned destagger_depth(input int unsigned p_factor_bits,
                                                  input int unsigned first_dsp_registers,
                                                  input int unsigned dsp_registers);
    return (p_lanes(p_factor_bits) - 1) * stagger_step(first_dsp_registers, dsp_registers);
  endfunction

  function automatic int unsigned latency(input int unsigned p_factor_bits,
                                          input int unsigned first_dsp_registers,
                                          input int unsigned dsp_registers);
    return destagger_depth(p_factor_bits, first_dsp_registers, dsp_registers) + 1;
  endfunction

  // LSB of the complex sample for lane k of polarisation p.
  function automatic int unsigned lane_lsb(input int unsigned pol,
                                           input int unsigned lane,
                                           input int unsigned p_factor_bits,
                                           input int unsigned bitwidth);
    return (pol * p_lanes(p_factor_bits) + lane) * 2 * bitwidth;
  endfunction

  // MSB of both real and imag components of one complex sample.
  function automatic logic [63:0] offb_mask(input int unsigned bitwidth);
    logic [63:0] m;
    m = '0;
    m[bitwidth - 1]     = 1'b1;
    m[2 * bitwidth - 1] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/xeng_lane_delay.sv
// Fixed-depth delay line; DEPTH=0 is a plain wire.
// RESET_EN selects a clearable pipe, otherwise the pipe stays SRL-friendly.
module xeng_lane_delay #(
  parameter int unsigned DEPTH    = 1,
  parameter int unsigned WIDTH    = 1,
  parameter bit          RESET_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic ports_unused;
    assign ports_unused = clk ^ rst;
    assign dout         = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];
    logic             clr;

    assign clr = RESET_EN && rst;

    always_comb begin
      pipe_d[0] = din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (clr) begin
        pipe_q <= '{default: '0};
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign dout = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/xeng_postproc.sv
// X-engine output post-processor: de-staggers lanes, converts offset-binary to
// two's complement and frames accumulation windows behind a delayed sync.
module xeng_postproc
  import xeng_pkg::*;
#(
  parameter int unsigned SERIAL_ACC_LEN_BITS = 7,
  parameter int unsigned P_FACTOR_BITS       = 2,
  parameter int unsigned BITWIDTH            = 4,
  parameter int unsigned N_POLS              = 2,
  parameter int unsigned FIRST_DSP_REGISTERS = 2,
  parameter int unsigned DSP_REGISTERS       = 2,
  localparam int unsigned W = bus_width(N_POLS, P_FACTOR_BITS, BITWIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         sync,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         sync_out,
  output logic         acc_valid,
  output logic         acc_last
);

  localparam int unsigned P  = p_lanes(P_FACTOR_BITS);
  localparam int unsigned S  = stagger_step(FIRST_DSP_REGISTERS, DSP_REGISTERS);
  localparam int unsigned D  = destagger_depth(P_FACTOR_BITS, FIRST_DSP_REGISTERS, DSP_REGISTERS);
  localparam int unsigned CW = 2 * BITWIDTH;
  localparam logic [CW-1:0] FLIP = CW'(offb_mask(BITWIDTH));
  localparam logic [SERIAL_ACC_LEN_BITS-1:0] CNT_LAST = '1;

  logic ce_unused;
  assign ce_unused = ce;

  logic [W-1:0] aligned;
  logic [W-1:0] converted;
  logic         sync_pre;

  for (genvar p = 0; p < N_POLS; p++) begin : g_pol
    for (genvar k = 0; k < P; k++) begin : g_lane
      localparam int unsigned LSB = lane_lsb(p, k, P_FACTOR_BITS, BITWIDTH);
      xeng_lane_delay #(
        .DEPTH    ((P - 1 - k) * S),
        .WIDTH    (CW),
        .RESET_EN (1'b0)
      ) u_lane_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (din[LSB +: CW]),
        .dout (aligned[LSB +: CW])
      );
    end
  end

  // Sync runs one stage short of the data so framing registers with dout.
  xeng_lane_delay #(
    .DEPTH    (D),
    .WIDTH    (1),
    .RESET_EN (1'b1)
  ) u_sync_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (sync),
    .dout (sync_pre)
  );

  assign converted = aligned ^ {(N_POLS * P){FLIP}};

  frame_state_e                   state_q,    state_d;
  logic [SERIAL_ACC_LEN_BITS-1:0] cnt_q,      cnt_d;
  logic [W-1:0]                   dout_q,     dout_d;
  logic                           sync_out_q, sync_out_d;
  logic                           acc_last_q, acc_last_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    sync_out_d = sync_pre;
    if (sync_pre) begin
      state_d = FRAME_ACTIVE;
      cnt_d   = '0;
    end
    acc_last_d = (state_d == FRAME_ACTIVE) && (cnt_d == CNT_LAST);
    dout_d     = (state_d == FRAME_ACTIVE) ? converted : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FRAME_IDLE;
      cnt_q      <= '0;
      dout_q     <= '0;
      sync_out_q <= 1'b0;
      acc_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      sync_out_q <= sync_out_d;
      acc_last_q <= acc_last_d;
    end
  end

  assign dout      = dout_q;
  assign sync_out  = sync_out_q;
  assign acc_valid = (state_q == FRAME_ACTIVE);
  assign acc_last  = acc_last_q;

endmodule

// File: tb/tb_xeng_postproc.sv
// Scoreboard bench for xeng_postproc: default stagger (S=1) and S=2 instances
// checked against a history-based reference model.
module tb_xeng_postproc;

  localparam int BW    = 4;
  localparam int P     = 4;
  localparam int NPOL  = 2;
  localparam int CW    = 2 * BW;
  localparam int W     = NPOL * P * CW;
  localparam int WIN   = 128;
  localparam int HALF  = 1 << (BW - 1);
  localparam int HMAX  = 4096;

  typedef struct {
    logic [W-1:0] dout;
    logic         so;
    logic         v;
    logic         l;
  } exp_t;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         ce   = 1'b1;
  logic         sync = 1'b0;
  logic [W-1:0] din  = '0;

  logic [W-1:0] dout0, dout1;
  logic         so0, so1, v0, v1, l0, l1;

  always #5 clk = ~clk;

  xeng_postproc #(
    .SERIAL_ACC_LEN_BITS (7),
    .P_FACTOR_BITS       (2),
    .BITWIDTH            (BW),
    .N_POLS              (NPOL),
    .FIRST_DSP_REGISTERS (2),
    .DSP_REGISTERS       (2)
  ) dut0 (
    .clk (clk), .rst (rst), .ce (ce), .sync (sync), .din (din),
    .dout (dout0), .sync_out (so0), .acc_valid (v0), .acc_last (l0)
  );

  xeng_postproc #(
    .SERIAL_ACC_LEN_BITS (7),
    .P_FACTOR_BITS       (2),
    .BITWIDTH            (BW),
    .N_POLS              (NPOL),
    .FIRST_DSP_REGISTERS (2),
    .DSP_REGISTERS       (3)
  ) dut1 (
    .clk (clk), .rst (rst), .ce (ce), .sync (sync), .din (din),
    .dout (dout1), .sync_out (so1), .acc_valid (v1), .acc_last (l1)
  );

  // Sampled-input history, indexed by the clock edge that samples it.
  logic [W-1:0] din_h  [HMAX];
  logic         sync_h [HMAX];
  logic         rst_h  [HMAX];
  int           e = 0;

  int last_so  [2] = '{-100000, -100000};
  int last_rst [2] = '{-100000, -100000};
  int valid_m  [2] = '{0, 0};

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge~%0d actual=%h required=%h", name, e, act, req);
    end
  endtask

  // Expected outputs after edge e for an instance with stagger s, latency l.
  task automatic predict(input int i, input int s, input int l, output exp_t x);
    int src, src_d, lsb;
    logic [BW-1:0] u;
    x.dout = '0; x.so = 1'b0; x.v = 1'b0; x.l = 1'b0;
    if (rst_h[e]) begin
      last_rst[i] = e;
      valid_m[i]  = 0;
      return;
    end
    src = e - (l - 1);
    if (src >= 0 && sync_h[src] && last_rst[i] < src) begin
      last_so[i] = e;
      valid_m[i] = 1;
      x.so       = 1'b1;
    end
    if (valid_m[i] == 0) return;
    x.v = 1'b1;
    x.l = (((e - last_so[i]) % WIN) == WIN - 1);
    for (int p = 0; p < NPOL; p++) begin
      for (int k = 0; k < P; k++) begin
        src_d = e - (l - 1) + k * s;
        for (int j = 0; j < 2; j++) begin
          lsb = (p * P + k) * CW + j * BW;
          u   = din_h[src_d][lsb +: BW];
          x.dout[lsb +: BW] = BW'(int'(u) - HALF);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [W-1:0] d);
    exp_t x;
    @(negedge clk);
    rst  = r;
    sync = s;
    din  = d;
    if (e >= HMAX) begin
      $display("FAIL history_overflow edge=%0d", e);
      $fatal(1, "history overflow");
    end
    rst_h[e]  = r;
    sync_h[e] = s;
    din_h[e]  = d;
    predict(0, 1, 4, x);
    q0.push_back(x);
    predict(1, 2, 7, x);
    q1.push_back(x);
    e++;
  endtask

  function automatic logic [W-1:0] rnd();
    return W'({$urandom, $urandom});
  endfunction

  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      check("dut0_dout",      64'(dout0), 64'(x.dout));
      check("dut0_sync_out",  64'(so0),   64'(x.so));
      check("dut0_acc_valid", 64'(v0),    64'(x.v));
      check("dut0_acc_last",  64'(l0),    64'(x.l));
    end
    if (q1.size() > 0) begin
      x = q1.pop_front();
      check("dut1_dout",      64'(dout1), 64'(x.dout));
      check("dut1_sync_out",  64'(so1),   64'(x.so));
      check("dut1_acc_valid", 64'(v1),    64'(x.v));
      check("dut1_acc_last",  64'(l1),    64'(x.l));
    end
  end

  initial begin : driver
    logic [W-1:0] d;

    repeat (4) step(1'b1, 1'b0, rnd());
    // No sync yet: everything must stay masked.
    repeat (200) step(1'b0, 1'b0, rnd());

    // Single sync with 0x9A on every lane across the stagger span.
    step(1'b0, 1'b1, {(W/CW){8'h9A}});
    repeat (8) step(1'b0, 1'b0, {(W/CW){8'h9A}});
    repeat (290) step(1'b0, 1'b0, rnd());

    // Component ramp through every offset-binary code, distinct per slot.
    for (int c = 0; c < 40; c++) begin
      for (int j = 0; j < W / BW; j++) d[j*BW +: BW] = BW'(c + j);
      step(1'b0, 1'b0, d);
    end

    // Mid-window restart.
    step(1'b0, 1'b1, rnd());
    repeat (49) step(1'b0, 1'b0, rnd());
    step(1'b0, 1'b1, rnd());
    repeat (200) step(1'b0, 1'b0, rnd());

    // Back-to-back and closely spaced syncs.
    repeat (3) step(1'b0, 1'b1, rnd());
    step(1'b0, 1'b0, rnd());
    step(1'b0, 1'b1, rnd());
    repeat (20) step(1'b0, 1'b0, rnd());

    // Reset when the default instance is at cnt=60; a sync during reset is lost.
    step(1'b0, 1'b1, rnd());
    repeat (62) step(1'b0, 1'b0, rnd());
    step(1'b1, 1'b0, rnd());
    step(1'b1, 1'b0, rnd());
    step(1'b1, 1'b1, rnd());
    repeat (30) step(1'b0, 1'b0, rnd());
    step(1'b0, 1'b1, rnd());
    repeat (150) step(1'b0, 1'b0, rnd());

    // Random syncs and resets.
    for (int c = 0; c < 800; c++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0), rnd());
    end
    repeat (10) step(1'b0, 1'b0, rnd());

    repeat (3) @(negedge clk);
    check("queue_drain", 64'(q0.size() + q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xeng_postproc.md
# xeng_postproc

Output-side counterpart of the X-engine input pre-processor. It takes the staggered, offset-binary (uint) sample bus as it emerges from the DSP cmult/accumulate chain and removes the per-lane stagger so that all parallel lanes are time-aligned again. It converts every component back to two's complement and regenerates an aligned sync together with accumulation-window framing (`acc_valid`, `acc_last`) for the downstream vector accumulator / packetiser.

## Interface
Parameters:
- `SERIAL_ACC_LEN_BITS`, 7 — accumulation window length is 2^N cycles
- `P_FACTOR_BITS`, 2 — parallel lanes per polarisation, P = 2^N
- `BITWIDTH`, 4 — bits per real/imag component
- `N_POLS`, 2 — number of polarisations
- `FIRST_DSP_REGISTERS`, 2 — input registers on the first DSP in the chain
- `DSP_REGISTERS`, 2 — input registers on every other DSP

Derived values:
- Stagger step S = 1 + (DSP_REGISTERS − FIRST_DSP_REGISTERS)
- Bus width W = N_POLS·P·2·BITWIDTH

Ports:
- `clk` in 1 — single clock
- `rst` in 1 — synchronous, active-high reset
- `ce` in 1 — unused clock enable, kept for Simulink compatibility
- `sync` in 1 — window start, aligned with the lane-0 sample of the staggered bus
- `din` in W — staggered uint bus
- `dout` out W — aligned, two's-complement bus
- `sync_out` out 1 — sync aligned with `dout`
- `acc_valid` out 1 — `dout` is inside a framed window
- `acc_last` out 1 — final cycle of the accumulation window

## Operation
- Bus layout, identical for `din` and `dout`:
  - Lane k of pol p occupies bits [(p·P+k)·2·BITWIDTH +: 2·BITWIDTH].
  - Real part is in the upper BITWIDTH bits, imag in the lower.
- Input stagger: lane k of `din` lags lane 0 by k·S cycles.
- De-stagger: lane k is delayed by (P−1−k)·S cycles, so every lane sees a total delay D = (P−1)·S.
- Conversion: each component is XORed with 1<<(BITWIDTH−1), mapping offset-binary to two's complement (uint 0 → −2^(BITWIDTH−1)). This is applied in one output register stage.
- `sync` is delayed by L = D+1 cycles to give `sync_out`.
- Window counter `cnt` is SERIAL_ACC_LEN_BITS wide:
  - Loads 0 in the cycle `sync_out` is high.
  - Otherwise increments and wraps at 2^N−1.
  - `acc_last` = `acc_valid` and `cnt` == 2^N−1.
- `acc_valid` goes high on the first `sync_out` after reset and stays high until the next reset.
- A `sync` arriving mid-window restarts the window. `cnt` returns to 0 at the new `sync_out`, and the truncated window gets no `acc_last`.
- Back-to-back `sync` pulses: every `sync_out` resets `cnt` to 0.
- While `acc_valid` is low, `dout` is forced to 0.

## Timing
- Latency from `din` lane 0 / `sync` to `dout` / `sync_out` is L = (P−1)·S + 1 cycles. Defaults give S=1, D=3, L=4.
- Lane k data enters at cycle t0 + k·S and exits at t0 + L.
- Reset values: `dout`=0, `sync_out`=0, `acc_valid`=0, `acc_last`=0, `cnt`=0.
- Reset also clears the sync delay pipe. A `sync` inside the L cycles before reset deasserts is lost.
- The data delay lines are not reset (SRL-friendly). Their stale contents are masked by `acc_valid`=0.
- Reset asserted mid-window: all outputs are 0 on the cycle after `rst` is sampled high. Framing resumes only at the next `sync_out`.
- No backpressure. One sample set is accepted every clock and `ce` is ignored.

## Structure
- Shared package `xeng_pkg` holds:
  - functions for P, W, S, D, L
  - the lane-slice index function
  - the offset-binary/two's-complement MSB mask constant
- Sub-module `xeng_lane_delay`: parameterised delay (DEPTH, WIDTH), with a DEPTH=0 passthrough. It is instantiated once per lane per pol and once, with reset, for sync.
- Counter, framing and output register live in the top level.

## Test plan
- Reset then one sync: drive `sync` at t=10 with lane k of every pol = uint 0x9A presented at t=10+k. Expect:
  - `sync_out`, `acc_valid` rise at t=14
  - all lanes of `dout` = 0x12 at t=14
  - `acc_last` at t=141
  - `cnt` wraps and `acc_last` recurs at t=269
- Mapping sweep: ramp each component through uint 0..15. Expect signed outputs −8..7 (0→−8, 8→0, 15→7), with no lane cross-talk.
- Mid-window sync: second `sync` 50 cycles after the first. Expect:
  - `cnt`=0 at the second `sync_out`
  - no `acc_last` in the truncated window
  - next `acc_last` 127 cycles after the second `sync_out`
- Pre-sync masking: random `din`, no `sync`, for 200 cycles after reset. Expect `dout`=0 and `acc_valid`, `acc_last`, `sync_out` all 0.
- Reset mid-window at `cnt`=60. Expect all outputs 0 the next cycle, staying 0 until a new `sync` arrives plus 4 cycles.
- Stagger offset: with DSP_REGISTERS=3, FIRST_DSP_REGISTERS=2 (S=2, L=7), lane k is presented at t0+2k. Expect `dout` aligned at t0+7.
